// File: rtl/mio_dmem_bridge_pkg.sv
// Shared access-size codes and FSM state type for the load/store bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mio_dmem_bridge_pkg;

    // Access size/sign codes carried on cpu_dmtype; 101..111 are illegal.
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mio_dmem_bridge_if.sv
// Word-wide memory/peripheral bus: req held until ready, completes in the ready cycle.
// Latency: n/a (signal bundle).
// Backpressure: slave stretches an access by holding bus_ready low.
interface mio_dmem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/mio_dmem_bridge_lane_align.sv
// Byte-lane steering: store enables/replication, load lane select + extension, fault detect.
// Latency: purely combinational.
// Backpressure: none.
module mio_lane_align
    import mio_dmem_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmtype,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords are only legal on even addresses, so addr_lo[1] alone picks the lane.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Enables, store replication and alignment fault from access size and low address bits.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        misalign   = 1'b0;
        case (dmtype)
            DM_WORD: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            DM_BYTE, DM_BYTE_U: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            default: misalign = 1'b1;
        endcase
    end

    // Right-justify the selected load lane and sign- or zero-extend it.
    always_comb begin
        rdata_ext = rdata;
        case (dmtype)
            DM_HALF:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            DM_HALF_U: rdata_ext = {16'h0000, half_sel};
            DM_BYTE:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: rdata_ext = {24'h000000, byte_sel};
            default:   rdata_ext = rdata;
        endcase
    end
endmodule

// File: rtl/mio_dmem_bridge.sv
// Load/store bridge from the CPU MEM stage to a word bus; optional wait timeout (MIO_TIMEOUT_EN).
// Latency: 3 cycles request->done with immediate ready, +1 per wait cycle; 2 cycles on a fault.
// Backpressure: stalls the core while accepting/busy; bus stretches accesses via bus_ready.
module mio_dmem_bridge
    import mio_dmem_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_dmtype,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic              cpu_misalign,
    mio_dmem_bridge_if.master bus
`ifdef MIO_TIMEOUT_EN
    ,
    output logic              bus_timeout
`endif
);
    state_t            state_q, state_d;
    logic              in_idle, in_busy, in_done, accept, expire;
    logic              we_q, mis_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [2:0]        dmtype_q;

    logic [1:0]  al_addr;
    logic [2:0]  al_dmtype;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis;

    assign in_idle = (state_q == ST_IDLE);
    assign in_busy = (state_q == ST_BUSY);
    assign in_done = (state_q == ST_DONE);
    assign accept  = in_idle & cpu_req;

    // One aligner serves both phases: live core inputs for the fault check at accept,
    // the frozen request while the bus access is in flight.
    assign al_addr   = in_idle ? cpu_addr[1:0] : addr_q[1:0];
    assign al_dmtype = in_idle ? cpu_dmtype    : dmtype_q;

    mio_lane_align u_align (
        .addr_lo    (al_addr),
        .dmtype     (al_dmtype),
        .wdata      (wdata_q),
        .rdata      (bus.bus_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misalign   (al_mis)
    );

`ifdef MIO_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    logic [15:0] wait_q;
    logic        timeout_q;

    // A ready arriving on the last allowed cycle completes normally.
    assign expire = in_busy & ~bus.bus_ready & (wait_q == 16'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles; remember whether the access ended by timing out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q <= in_busy ? wait_q + 16'd1 : 16'd0;
            if (accept)      timeout_q <= 1'b0;
            else if (expire) timeout_q <= 1'b1;
        end
    end

    assign bus_timeout = in_done & timeout_q;
`else
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;
    logic unused_timeout_cfg;

    // Without the wait counter BUSY waits for the bus indefinitely.
    assign expire             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; faulting requests skip the bus entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cpu_req) state_d = al_mis ? ST_DONE : ST_BUSY;
            ST_BUSY: if (bus.bus_ready || expire) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at accept; it stays frozen until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dmtype_q <= DM_WORD;
        end else if (accept) begin
            we_q     <= cpu_we;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            dmtype_q <= cpu_dmtype;
        end
    end

    // Result: cleared at accept (covers faults and stores), loaded on bus completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= '0;
            mis_q   <= al_mis;
        end else if (in_busy && bus.bus_ready) begin
            rdata_q <= we_q ? 32'h0 : al_rdata;
        end else if (expire) begin
            rdata_q <= TIMEOUT_RDATA;
        end
    end

    assign cpu_stall    = accept | in_busy;
    assign cpu_done     = in_done;
    assign cpu_misalign = in_done & mis_q;
    assign cpu_rdata    = rdata_q;

    assign bus.bus_req   = in_busy;
    assign bus.bus_we    = in_busy & we_q;
    assign bus.bus_addr  = in_busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.bus_be    = in_busy ? al_be : 4'b0000;
    assign bus.bus_wdata = in_busy ? al_wdata : 32'h0;
endmodule

// File: tb/tb_mio_dmem_bridge.sv
// Bench for mio_dmem_bridge: randomized accesses against a size/lane arithmetic model.
// Latency: the model predicts every cycle of each access from the wait count it chooses.
// Backpressure: the bench plays the bus slave and picks the number of wait cycles.
module tb_mio_dmem_bridge;
    import mio_dmem_bridge_pkg::*;

`ifdef MIO_TIMEOUT_EN
    localparam int MAX_WAIT = 3;
`else
    localparam int MAX_WAIT = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_dmtype;
    logic        cpu_done, cpu_stall, cpu_misalign;
`ifdef MIO_TIMEOUT_EN
    logic        bus_timeout;
`endif

    mio_dmem_bridge_if #(.ADDR_W(32)) bus_if ();

    mio_dmem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_dmtype   (cpu_dmtype),
        .cpu_rdata    (cpu_rdata),
        .cpu_done     (cpu_done),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .bus          (bus_if)
`ifdef MIO_TIMEOUT_EN
        ,
        .bus_timeout  (bus_timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle, written by the stimulus process.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_breq, exp_bwe, exp_mis;
    logic [31:0] exp_baddr, exp_bwdata, exp_rdata;
    logic [3:0]  exp_bbe;

    // Observations of the last access, used for literal checks.
    int          obs_lat;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic        obs_mis, obs_breq_any;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%h want 0x%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [2:0] dm);
        case (dm)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] dm, input logic [1:0] a);
        int n = size_of(dm);
        if (n == 0) return 1'b1;
        return (int'(a) % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] dm, input logic [1:0] a);
        int n = size_of(dm);
        int v = ((1 << n) - 1) << int'(a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] dm, input logic [31:0] d);
        case (size_of(dm))
            1:       return {24'h0, d[7:0]} * 32'h0101_0101;
            2:       return {16'h0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] dm, input logic [1:0] a,
                                               input logic [31:0] rd);
        int          n    = size_of(dm);
        logic [63:0] mask = (64'h1 << (8 * n)) - 64'h1;
        logic [63:0] v    = ({32'h0, rd} >> (8 * int'(a))) & mask;
        bit          sgn  = (dm == 3'd1) || (dm == 3'd3);
        if (sgn && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
            chk("cpu_done",  32'(cpu_done),  32'(exp_done));
            chk("bus_req",   32'(bus_if.bus_req), 32'(exp_breq));
            if (exp_breq) begin
                chk("bus_we",   32'(bus_if.bus_we), 32'(exp_bwe));
                chk("bus_addr", bus_if.bus_addr, exp_baddr);
                chk("bus_be",   32'(bus_if.bus_be), 32'(exp_bbe));
                if (exp_bwe) chk("bus_wdata", bus_if.bus_wdata, exp_bwdata);
            end
            if (exp_done) begin
                chk("cpu_rdata",    cpu_rdata, exp_rdata);
                chk("cpu_misalign", 32'(cpu_misalign), 32'(exp_mis));
`ifdef MIO_TIMEOUT_EN
                chk("bus_timeout",  32'(bus_timeout), 32'h0);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic junk_inputs();
        cpu_we     = 1'($urandom);
        cpu_addr   = $urandom;
        cpu_wdata  = $urandom;
        cpu_dmtype = 3'($urandom);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            cpu_req = 1'b0;
            junk_inputs();
            bus_if.bus_ready = 1'($urandom);
            bus_if.bus_rdata = $urandom;
            exp_stall = 1'b0; exp_done = 1'b0; exp_breq = 1'b0;
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // Entered just after a rising edge with the bridge idle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] dm, input logic [31:0] rd, input int waits);
        bit mis  = model_mis(dm, addr[1:0]);
        int ncyc = mis ? 2 : waits + 3;
        obs_lat = -1;
        obs_breq_any = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            exp_stall = 1'b0; exp_done = 1'b0; exp_breq = 1'b0;
            bus_if.bus_ready = 1'($urandom);
            bus_if.bus_rdata = $urandom;
            if (c == 0) begin
                cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_dmtype = dm;
                exp_stall = 1'b1;
            end else if (c == ncyc - 1) begin
                cpu_req = 1'b1;
                junk_inputs();
                exp_done  = 1'b1;
                exp_mis   = mis;
                exp_rdata = (mis || we) ? 32'h0 : model_load(dm, addr[1:0], rd);
            end else begin
                cpu_req = 1'($urandom);
                junk_inputs();
                exp_stall  = 1'b1;
                exp_breq   = 1'b1;
                exp_bwe    = we;
                exp_baddr  = {addr[31:2], 2'b00};
                exp_bbe    = model_be(dm, addr[1:0]);
                exp_bwdata = model_wdata(dm, wd);
                bus_if.bus_ready = (c == ncyc - 2);
                if (c == ncyc - 2) bus_if.bus_rdata = rd;
            end
            chk_en = 1'b1;
            @(negedge clk);
            if (bus_if.bus_req) begin
                obs_breq_any = 1'b1;
                obs_be = bus_if.bus_be; obs_addr = bus_if.bus_addr; obs_wdata = bus_if.bus_wdata;
            end
            if (cpu_done && obs_lat < 0) begin
                obs_lat = c + 1; obs_rdata = cpu_rdata; obs_mis = cpu_misalign;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dmtype = '0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall",   32'(cpu_stall), 32'h0);
        chk("rst_done",    32'(cpu_done), 32'h0);
        chk("rst_mis",     32'(cpu_misalign), 32'h0);
        chk("rst_rdata",   cpu_rdata, 32'h0);
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'h0);
        chk("rst_bus_be",  32'(bus_if.bus_be), 32'h0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Word store, two wait cycles.
        run_txn(1'b1, 32'h100, 32'h1122_3344, DM_WORD, 32'h0, 2);
        chk("ws_be",   32'(obs_be), 32'hF);
        chk("ws_addr", obs_addr, 32'h100);
        chk("ws_lat",  32'(obs_lat), 32'd5);
        idle(1);

        // Byte load from lane 3, signed then unsigned.
        run_txn(1'b0, 32'h203, 32'h0, DM_BYTE, 32'h80FF_0000, 0);
        chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        chk("lb_be",    32'(obs_be), 32'h8);
        run_txn(1'b0, 32'h203, 32'h0, DM_BYTE_U, 32'h80FF_0000, 1);
        chk("lbu_rdata", obs_rdata, 32'h0000_0080);
        idle(2);

        // Upper-half store.
        run_txn(1'b1, 32'h302, 32'h0000_ABCD, DM_HALF, 32'h0, 0);
        chk("sh_be",    32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        chk("sh_addr",  obs_addr, 32'h300);

        // Misaligned word load: no bus traffic, fault in two cycles.
        run_txn(1'b0, 32'h101, 32'h0, DM_WORD, 32'h1234_5678, 0);
        chk("mis_breq",  32'(obs_breq_any), 32'h0);
        chk("mis_flag",  32'(obs_mis), 32'h1);
        chk("mis_rdata", obs_rdata, 32'h0);
        chk("mis_lat",   32'(obs_lat), 32'd2);

        // Back-to-back with request held through DONE.
        run_txn(1'b0, 32'h404, 32'h0, DM_HALF_U, 32'h8765_4321, 0);
        chk("b2b_rdata", obs_rdata, 32'h0000_4321);
        run_txn(1'b0, 32'h406, 32'h0, DM_HALF, 32'h8765_4321, 0);
        chk("b2b_lat",   32'(obs_lat), 32'd3);
        chk("b2b_rdata2", obs_rdata, 32'hFFFF_8765);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            idle($urandom_range(0, 2));
            run_txn(1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, MAX_WAIT));
        end
        idle(1);

        // Reset while BUSY abandons the access.
        chk_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_dmtype = DM_WORD;
        bus_if.bus_ready = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_busy_pre", 32'(bus_if.bus_req), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy_breq",  32'(bus_if.bus_req), 32'h0);
        chk("rst_busy_stall", 32'(cpu_stall), 32'h0);
        bus_if.bus_ready = 1'b1;
        done_seen = 0;
        repeat (2) begin @(negedge clk); if (cpu_done) done_seen++; end
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (cpu_done) done_seen++; end
        chk("rst_busy_nodone", 32'(done_seen), 32'h0);
        @(posedge clk); #1;

`ifdef MIO_TIMEOUT_EN
        // Bus never answers: timeout after four BUSY cycles.
        begin
            int lat = -1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; cpu_dmtype = DM_WORD;
            bus_if.bus_ready = 1'b0;
            for (int c = 0; c < 20 && lat < 0; c++) begin
                @(negedge clk);
                if (cpu_done) begin
                    lat = c + 1;
                    chk("to_flag",  32'(bus_timeout), 32'h1);
                    chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
                end
                @(posedge clk); #1;
                cpu_req = 1'b0;
            end
            chk("to_lat", 32'(lat), 32'd6);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
